// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter: round-robin arbiter sharing one combinational FP add/sub unit between two requesters.
module fp_addsub_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic             req0_op,
  input  logic             req1_op,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp_s,
  output logic             rsp_overflow,
  output logic             rsp_underflow,
  output logic [31:0]      fu_a,
  output logic [31:0]      fu_b,
  output logic             fu_op,
  input  logic [31:0]      fu_s,
  input  logic             fu_overflow,
  input  logic             fu_underflow,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] unf_cnt
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t      state;
  logic        last_grant, owner, op_q, ovf_q, unf_q;
  logic [31:0] a_q, b_q, s_q;
  logic        gnt0, gnt1;
  // rst_n gates the grants so ready stays low while reset is held
  assign gnt0 = rst_n && state == IDLE && req0_valid && (!req1_valid || last_grant);
  assign gnt1 = rst_n && state == IDLE && req1_valid && (!req0_valid || !last_grant);
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp0_valid = state == RESP && !owner;
  assign rsp1_valid = state == RESP && owner;
  assign rsp_s = s_q;
  assign rsp_overflow = ovf_q;
  assign rsp_underflow = unf_q;
  assign fu_a = a_q;
  assign fu_b = b_q;
  assign fu_op = op_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= 1'b1;
      owner <= 1'b0;
      op_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (gnt0 || gnt1) begin
          owner <= gnt1;
          last_grant <= gnt1;
          op_q <= gnt1 ? req1_op : req0_op;
          a_q <= gnt1 ? req1_a : req0_a;
          b_q <= gnt1 ? req1_b : req0_b;
          state <= EXEC;
        end
        EXEC: begin
          s_q <= fu_s;
          ovf_q <= fu_overflow;
          unf_q <= fu_underflow;
          if (fu_overflow && !(&ovf_cnt)) ovf_cnt <= ovf_cnt + CNT_W'(1);
          if (fu_underflow && !(&unf_cnt)) unf_cnt <= unf_cnt + CNT_W'(1);
          state <= RESP;
        end
        RESP: if (owner ? rsp1_ready : rsp0_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// tb_fp_addsub_arbiter: directed scoreboard bench with a table-driven model of the shared FP unit.
module tb_fp_addsub_arbiter;
  localparam int CW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid, req1_valid, req0_ready, req1_ready, req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp_s, fu_a, fu_b, fu_s;
  logic rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready, rsp_overflow, rsp_underflow;
  logic fu_op, fu_overflow, fu_underflow;
  logic [CW-1:0] ovf_cnt, unf_cnt;
  typedef struct {logic who; logic [31:0] s; logic ovf; logic unf;} exp_t;
  exp_t sb[$];
  int n_pass = 0, n_chk = 0;
  logic who;

  always #5 clk = ~clk;

  fp_addsub_arbiter #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_s(rsp_s), .rsp_overflow(rsp_overflow), .rsp_underflow(rsp_underflow),
    .fu_a(fu_a), .fu_b(fu_b), .fu_op(fu_op),
    .fu_s(fu_s), .fu_overflow(fu_overflow), .fu_underflow(fu_underflow),
    .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
  );

  // Known IEEE-754 results for the operand pairs used here; anything else yields a marker value
  function automatic logic [33:0] fp_lut(input logic [31:0] a, input logic [31:0] b, input logic op);
    case ({op, a, b})
      {1'b1, 32'h40C00000, 32'h40400000}: return {32'h40400000, 2'b00};
      {1'b1, 32'hC0C00000, 32'h40400000}: return {32'hC1100000, 2'b00};
      {1'b1, 32'hC0400000, 32'hC0C00000}: return {32'h40400000, 2'b00};
      {1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF}: return {32'h7F800000, 2'b10};
      {1'b1, 32'h40B00000, 32'h40B00000}: return {32'h00000000, 2'b00};
      {1'b1, 32'h00800001, 32'h00800000}: return {32'h00000001, 2'b01};
      {1'b0, 32'h3F800000, 32'h40000000}: return {32'h40400000, 2'b00};
      default: return {32'hFFFFFFFF, 2'b00};
    endcase
  endfunction

  always_comb {fu_s, fu_overflow, fu_underflow} = fp_lut(fu_a, fu_b, fu_op);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_accept(output logic w);
    int k = 0;
    exp_t e;
    #1;
    while (!(req0_ready || req1_ready) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("accept_seen", 64'(req0_ready | req1_ready), 64'd1);
    chk("ready_onehot", 64'(req0_ready & req1_ready), 64'd0);
    w = req1_ready;
    e.who = w;
    {e.s, e.ovf, e.unf} = fp_lut(w ? req1_a : req0_a, w ? req1_b : req0_b, w ? req1_op : req0_op);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic wait_rsp();
    int lat = 1;
    exp_t e;
    while (!(rsp0_valid || rsp1_valid) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'd2);
    chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("owner_valid", 64'({rsp1_valid, rsp0_valid}), e.who ? 64'd2 : 64'd1);
      chk("rsp_s", 64'(rsp_s), 64'(e.s));
      chk("flags", 64'({rsp_overflow, rsp_underflow}), 64'({e.ovf, e.unf}));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hs"}, 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid}), 64'd0);
    chk({tag, "_fu"}, {fu_a, fu_b}, 64'd0);
    chk({tag, "_rsp"}, 64'({rsp_s, rsp_overflow, rsp_underflow, fu_op}), 64'd0);
    chk({tag, "_cnt"}, 64'({ovf_cnt, unf_cnt}), 64'd0);
  endtask

  initial begin
    req0_valid = 1'b1; req0_op = 1'b1; req0_a = 32'hC0C00000; req0_b = 32'h40400000;
    req1_valid = 1'b1; req1_op = 1'b1; req1_a = 32'hC0400000; req1_b = 32'hC0C00000;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #2 chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    // sustained tie from reset: grants alternate starting with requester 0
    for (int i = 0; i < 4; i++) begin
      wait_accept(who);
      chk("rr_order", 64'(who), 64'(i[0]));
      chk("busy_no_ready", 64'({req0_ready, req1_ready}), 64'd0);
      wait_rsp();
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 1'b1; req0_a = 32'h40C00000; req0_b = 32'h40400000; req0_valid = 1'b1;
    wait_accept(who);
    req0_valid = 1'b0;
    chk("single_who", 64'(who), 64'd0);
    wait_rsp();
    @(negedge clk);
    rsp0_ready = 1'b0;
    req0_op = 1'b0; req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_valid = 1'b1;
    wait_accept(who);
    req0_valid = 1'b0;
    req1_op = 1'b1; req1_a = 32'h40B00000; req1_b = 32'h40B00000; req1_valid = 1'b1;
    wait_rsp();
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", 64'(rsp0_valid), 64'd1);
      chk("bp_s", 64'(rsp_s), 64'h40400000);
      chk("bp_req1_ready", 64'(req1_ready), 64'd0);
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("bp_done", 64'(rsp0_valid), 64'd0);
    wait_accept(who);
    req1_valid = 1'b0;
    chk("cancel_who", 64'(who), 64'd1);
    wait_rsp();
    chk("cancel_cnt", 64'({ovf_cnt, unf_cnt}), 64'd0);
    @(negedge clk);
    req0_op = 1'b1; req0_a = 32'h00800001; req0_b = 32'h00800000; req0_valid = 1'b1;
    wait_accept(who);
    req0_valid = 1'b0;
    wait_rsp();
    chk("unf_cnt", 64'(unf_cnt), 64'd1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      req0_op = 1'b0; req0_a = 32'h7F7FFFFF; req0_b = 32'h7F7FFFFF; req0_valid = 1'b1;
      wait_accept(who);
      req0_valid = 1'b0;
      wait_rsp();
      chk("ovf_cnt", 64'(ovf_cnt), (i + 1 > 3) ? 64'd3 : 64'(i + 1));
      @(negedge clk);
    end
    // abandon an overflowing op while it sits in EXEC
    req0_valid = 1'b1;
    wait_accept(who);
    req1_valid = 1'b1;
    rst_n = 1'b0;
    #1 chk_zero("midrst");
    sb.delete();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_quiet", 64'({rsp0_valid, rsp1_valid, ovf_cnt, unf_cnt}), 64'd0);
    end
    req1_op = 1'b1; req1_a = 32'hC0400000; req1_b = 32'hC0C00000; req1_valid = 1'b1;
    wait_accept(who);
    req1_valid = 1'b0;
    chk("post_rst_who", 64'(who), 64'd1);
    wait_rsp();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fp_addsub_arbiter.md
FP_ADDSUB_ARBITER -- requirements
Module: fp_addsub_arbiter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8: width of the saturating exception event counters.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have ports req0_valid / req1_valid, input, 1 each: requester 0/1 has an operation pending.
REQ-005 The block SHALL have ports req0_ready / req1_ready, output, 1 each: request accepted this cycle when valid and ready are both high.
REQ-006 The block SHALL have ports req0_op / req1_op, input, 1 each: 0 = add, 1 = subtract.
REQ-007 The block SHALL have ports req0_a, req0_b, req1_a, req1_b, input, 32 each: IEEE-754 single-precision operands.
REQ-008 The block SHALL have ports rsp0_valid / rsp1_valid, output, 1 each: result available for requester 0/1.
REQ-009 The block SHALL have ports rsp0_ready / rsp1_ready, input, 1 each: requester consumes the result.
REQ-010 The block SHALL have ports rsp_s (output, 32), rsp_overflow (output, 1) and rsp_underflow (output, 1), shared by both requesters and qualified by rspN_valid.
REQ-011 The block SHALL have ports fu_a and fu_b (output, 32 each) and fu_op (output, 1), driving the shared combinational add/sub unit.
REQ-012 The block SHALL have ports fu_s (input, 32), fu_overflow (input, 1) and fu_underflow (input, 1), the unit's combinational result.
REQ-013 The block SHALL have ports ovf_cnt and unf_cnt, output, CNT_W each: saturating counts of completed operations with overflow or underflow set.

Function
REQ-014 FSM states SHALL be IDLE, EXEC and RESP, with exactly one operation in flight at any time.
REQ-015 In IDLE, grant SHALL be round-robin: a lone valid requester wins; when both are valid, the requester not granted last wins.
REQ-016 The last_grant register SHALL reset to 1, so requester 0 wins the first tie.
REQ-017 reqN_ready SHALL be high only in IDLE and only for the granted requester; it SHALL be combinational from reqN_valid and last_grant.
REQ-018 On acceptance (cycle N), the block SHALL register op, a, b and the owner ID, update last_grant, and enter EXEC.
REQ-019 fu_a, fu_b and fu_op SHALL be driven only from the operand registers, never combinationally from the request inputs.
REQ-020 In EXEC (cycle N+1), the block SHALL capture fu_s, fu_overflow and fu_underflow into the result registers at the clock edge and enter RESP.
REQ-021 In RESP, rsp<owner>_valid SHALL be high from cycle N+2 onward, and the other rspN_valid SHALL be low.
REQ-022 rsp_s and the flags SHALL be held stable until the handshake completes.
REQ-023 When rsp<owner>_valid and rsp<owner>_ready are both high, the block SHALL return to IDLE on that edge; a new request SHALL be accepted no earlier than the following cycle.
REQ-024 Minimum initiation interval SHALL be 3 cycles, and latency from acceptance to rsp_valid SHALL be 2 cycles.
REQ-025 The non-owner rsp_ready input SHALL be ignored, and request inputs SHALL be ignored outside IDLE.
REQ-026 ovf_cnt SHALL increment by 1 in the EXEC cycle when fu_overflow=1, and SHALL hold at all-ones once saturated (no wrap).
REQ-027 unf_cnt SHALL follow the same rule as ovf_cnt, driven by fu_underflow; both counters MAY increment in the same cycle.
REQ-028 The block SHALL NOT modify operands; subtraction SHALL be requested solely via fu_op=1.

Reset
REQ-029 When rst_n=0, the block SHALL immediately, without waiting for a clock edge: enter IDLE; set last_grant=1; and clear operand, result, owner and counter registers.
REQ-030 During reset, all outputs SHALL be 0, including reqN_ready.
REQ-031 Reset asserted in EXEC or RESP SHALL abandon the in-flight operation, with no rsp_valid issued after release and no counter update.
REQ-032 After rst_n rises, the first acceptance SHALL be possible on the first clock edge.

Verification
REQ-033 Single subtract: req0 op=1, a=0x40C00000, b=0x40400000, unit modelled by the team's ieee754_add/ieee754_sub. Required response: req0_ready in cycle N; rsp0_valid at N+2 with rsp_s=0x40400000, flags 0; rsp1_valid=0.
REQ-034 Tie arbitration: both requests valid from reset, req0 = 0xC0C00000 - 0x40400000, req1 = 0xC0400000 - 0xC0C00000, rsp ready held high. Required response: req0 served first (rsp_s=0xC1100000), then req1 (rsp_s=0x40400000); grant order continues 0,1,0,1 under sustained ties.
REQ-035 Backpressure: rsp0_ready held low for 3 cycles after rsp0_valid. Required response: rsp_s stable; req1_ready stays 0; completion one cycle after rsp0_ready rises.
REQ-036 Exceptions: add 0x7F7FFFFF + 0x7F7FFFFF. Required response: rsp_overflow=1, ovf_cnt +1. With CNT_W=2 and five overflowing operations, ovf_cnt ends at 3.
REQ-037 Reset mid-operation: assert rst_n=0 during EXEC. Required response: all outputs 0 immediately; after release no rsp_valid appears; the next request completes normally with 2-cycle latency.
REQ-038 Cancellation: 0x40B00000 - 0x40B00000 via req1. Required response: rsp1_valid with rsp_s=0x00000000, counters unchanged.
